led_frame_swap_ctrl: RTL and testbench
======================================

# led_frame_swap_ctrl

Double-buffer controller for the 64x64 RGB LED panel. Owns two frame buffers in a shared pixel RAM: the display scanner reads the front buffer while a single writer (CPU/graphics) fills the back buffer. Swaps are requested by the writer and committed only on the scanner's end-of-frame `done` pulse, so no frame ever tears. An optional post-swap hardware clear fills the new back buffer. Sits between the writer, the pixel RAM write port and the `LEDDisplay` scanner, whose read address is `{frontSel, pixelAddress}`.

## Interface
- `ADDR_W`, 12, pixel address width within one frame (4096 pixels)
- `PIXEL_W`, 8, pixel data width
- `CLEAR_PIXEL`, 8'h00, value written by the clear engine

- `clk` in 1 system clock; all logic on rising edge
- `rst` in 1 synchronous, active-high reset
- `done` in 1 one-cycle end-of-frame pulse from the display scanner
- `swapReq` in 1 request to swap; sampled only while `swapReady`=1
- `clearReq` in 1 qualifier sampled with an accepted `swapReq`; 1 = clear new back buffer after swap
- `swapReady` out 1 controller accepts `swapReq` this cycle
- `swapAck` out 1 one-cycle pulse in the cycle `frontSel` changes
- `frontSel` out 1 buffer index the scanner reads
- `wrReq` in 1 writer pixel-write request
- `wrAddr` in ADDR_W writer pixel address
- `wrData` in PIXEL_W writer pixel value
- `wrReady` out 1 write accepted when `wrReq`&`wrReady`
- `ramWe` out 1 RAM write enable
- `ramAddr` out ADDR_W+1 RAM address, MSB = buffer index
- `ramData` out PIXEL_W RAM write data

## Operation
- States: READY, PENDING, CLEAR.
- READY: `swapReady`=1, `wrReady`=1. Accepted write at cycle N drives `ramWe`=1, `ramAddr`={~frontSel, wrAddr}, `ramData`=wrData at N+1. `swapReq`=1 latches `clearReq` → PENDING.
- PENDING: `swapReady`=0, `wrReady`=0 (writes stall; back buffer frozen). On `done`=1: toggle `frontSel`, pulse `swapAck`, go to CLEAR if latched clear else READY.
- CLEAR: `swapReady`=0, `wrReady`=0. 12-bit counter 0→4095; each cycle `ramWe`=1, `ramAddr`={~frontSel, count}, `ramData`=CLEAR_PIXEL. After writing 4095 → READY.
- Only one RAM writer per cycle; clear engine and writer never overlap by construction (`wrReady`=0 in CLEAR).
- `done` outside PENDING is ignored. `swapReq` outside READY is ignored (no queuing).

## Timing
- Reset values: state READY, `frontSel`=0, `swapReady`=1, `swapAck`=0, `wrReady`=1, `ramWe`=0, `ramAddr`=0, `ramData`=0, clear counter 0.
- Write latency: 1 cycle request→RAM strobe; full throughput (one write/cycle) in READY.
- `swapReq` accepted at N → state PENDING at N+1; `swapReady`/`wrReady` low from N+1. A write accepted at N still lands at N+1 in the old back buffer.
- `done` at cycle M in PENDING → `frontSel` toggled and `swapAck`=1 at M+1; READY/CLEAR at M+1.
- `swapReq` and `done` in the same READY cycle: `done` not honoured; swap waits for the next frame's `done`.
- CLEAR: first clear write at M+1, last at M+4096; `swapReady`/`wrReady`=1 at M+4097.
- Reset mid-PENDING or mid-CLEAR: abort immediately, return to reset values; buffer contents undefined.

## Structure
- Package `led_display_pkg`: state enum `swap_state_t` {READY, PENDING, CLEAR}, `FRAME_PIXELS`=4096, `PIXEL_ADDR_W`=12, `PIXEL_W`=8; shared with scanner and top level.
- Sub-module `led_clear_engine`: counter plus start/busy/last outputs, emits address/data/strobe; controller muxes it onto the RAM port.

## Test plan
- Reset: assert `rst` 2 cycles → all outputs at reset values, `frontSel`=0, `swapReady`=1.
- Writes: back-to-back `wrReq` at addrs 0,1,4095 with data 8'h11/22/33 → `ramWe` next cycles with `ramAddr` 13'h1000/1001/1FFF, matching data.
- Swap: `swapReq`(clear=0), `done` 5 cycles later → `swapAck` and `frontSel`=1 exactly one cycle after `done`; writes stalled between; next write lands at `ramAddr` MSB 0.
- Swap+clear: `swapReq`(clear=1), `done` → exactly 4096 `ramWe` cycles with data 8'h00 covering {~frontSel, 0..4095}, then `swapReady`=1.
- Corner: `swapReq`+`done` same cycle → no swap until next `done`; `done` while READY → no change; `swapReq` during CLEAR ignored.
- Reset at clear count 2000 → `ramWe`=0 next cycle, `frontSel`=0, state READY.

Source files
------------

// File: rtl/led_display_pkg.sv
// rtl/led_display_pkg.sv - shared types and constants for the LED panel frame path
package led_display_pkg;

    localparam int FRAME_PIXELS = 4096;
    localparam int PIXEL_ADDR_W = 12;
    localparam int PIXEL_W      = 8;

    typedef enum logic [1:0] {
        READY   = 2'd0,
        PENDING = 2'd1,
        CLEAR   = 2'd2
    } swap_state_t;

endpackage

// File: rtl/led_frame_swap_ctrl_if.sv
// rtl/led_frame_swap_ctrl_if.sv - writer, scanner and pixel RAM signals of the swap controller
interface led_frame_swap_ctrl_if #(
    parameter int ADDR_W  = 12,
    parameter int PIXEL_W = 8
) ();

    logic               done;
    logic               swapReq;
    logic               clearReq;
    logic               swapReady;
    logic               swapAck;
    logic               frontSel;
    logic               wrReq;
    logic [ADDR_W-1:0]  wrAddr;
    logic [PIXEL_W-1:0] wrData;
    logic               wrReady;
    logic               ramWe;
    logic [ADDR_W:0]    ramAddr;
    logic [PIXEL_W-1:0] ramData;

    // Environment side: scanner, writer, RAM
    modport master (
        output done, swapReq, clearReq, wrReq, wrAddr, wrData,
        input  swapReady, swapAck, frontSel, wrReady, ramWe, ramAddr, ramData
    );

    // Controller side
    modport slave (
        input  done, swapReq, clearReq, wrReq, wrAddr, wrData,
        output swapReady, swapAck, frontSel, wrReady, ramWe, ramAddr, ramData
    );

endinterface

// File: rtl/led_clear_engine.sv
// rtl/led_clear_engine.sv - sweeps one whole frame buffer with a constant clear pixel
module led_clear_engine #(
    parameter int                 ADDR_W      = 12,
    parameter int                 PIXEL_W     = 8,
    parameter logic [PIXEL_W-1:0] CLEAR_PIXEL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               back_sel_i,
    output logic               busy_o,
    output logic               last_o,
    output logic               we_o,
    output logic [ADDR_W:0]    addr_o,
    output logic [PIXEL_W-1:0] data_o
);

    logic              busy_q;
    logic [ADDR_W-1:0] count_q;

    // Run the counter from 0 to the last pixel once per start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            count_q <= '0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            count_q <= '0;
        end else if (busy_q) begin
            if (last_o) begin
                busy_q  <= 1'b0;
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // The strobe is live in every busy cycle, so the count itself is the write address
    always_comb begin
        busy_o = busy_q;
        last_o = busy_q && (&count_q);
        we_o   = busy_q;
        addr_o = {back_sel_i, count_q};
        data_o = CLEAR_PIXEL;
    end

endmodule

// File: rtl/led_frame_swap_ctrl.sv
// rtl/led_frame_swap_ctrl.sv - tear-free front/back frame buffer swap with optional back-buffer clear
module led_frame_swap_ctrl #(
    parameter int                 ADDR_W      = 12,
    parameter int                 PIXEL_W     = 8,
    parameter logic [PIXEL_W-1:0] CLEAR_PIXEL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    led_frame_swap_ctrl_if.slave  bus
);

    import led_display_pkg::*;

    swap_state_t        state_q, state_d;
    logic               front_sel_q;
    logic               clr_lat_q;
    logic               swap_ack_q;
    logic               wr_we_q;
    logic [ADDR_W:0]    wr_addr_q;
    logic [PIXEL_W-1:0] wr_data_q;

    logic               ready;
    logic               wr_fire;
    logic               swap_fire;
    logic               commit;
    logic               clr_start;
    logic               clr_busy;
    logic               clr_last;
    logic               clr_we;
    logic [ADDR_W:0]    clr_addr;
    logic [PIXEL_W-1:0] clr_data;

    // Handshake qualifiers; the swap only commits on the scanner's frame boundary
    always_comb begin
        ready     = (state_q == READY);
        wr_fire   = bus.wrReq & ready;
        swap_fire = bus.swapReq & ready;
        commit    = (state_q == PENDING) & bus.done;
        clr_start = commit & clr_lat_q;
    end

    led_clear_engine #(
        .ADDR_W      (ADDR_W),
        .PIXEL_W     (PIXEL_W),
        .CLEAR_PIXEL (CLEAR_PIXEL)
    ) u_clear (
        .clk        (clk),
        .rst        (rst),
        .start_i    (clr_start),
        .back_sel_i (~front_sel_q),
        .busy_o     (clr_busy),
        .last_o     (clr_last),
        .we_o       (clr_we),
        .addr_o     (clr_addr),
        .data_o     (clr_data)
    );

    // Next state: accept swaps only when idle, leave CLEAR after the last pixel
    always_comb begin
        state_d = state_q;
        case (state_q)
            READY:   if (bus.swapReq) state_d = PENDING;
            PENDING: if (bus.done)    state_d = clr_lat_q ? CLEAR : READY;
            CLEAR:   if (clr_last)    state_d = READY;
            default: state_d = READY;
        endcase
    end

    // State, buffer select and the one-cycle-delayed writer path into the back buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= READY;
            front_sel_q <= 1'b0;
            clr_lat_q   <= 1'b0;
            swap_ack_q  <= 1'b0;
            wr_we_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            swap_ack_q <= commit;
            wr_we_q    <= wr_fire;
            if (swap_fire) clr_lat_q <= bus.clearReq;
            if (commit) front_sel_q <= ~front_sel_q;
            if (wr_fire) begin
                wr_addr_q <= {~front_sel_q, bus.wrAddr};
                wr_data_q <= bus.wrData;
            end
        end
    end

    // Writer and clear engine never strobe in the same cycle, so a simple priority mux suffices
    always_comb begin
        bus.swapReady = ready;
        bus.wrReady   = ready;
        bus.swapAck   = swap_ack_q;
        bus.frontSel  = front_sel_q;
        bus.ramWe     = wr_we_q | clr_we;
        bus.ramAddr   = clr_busy ? clr_addr : wr_addr_q;
        bus.ramData   = clr_busy ? clr_data : wr_data_q;
    end

endmodule

// File: tb/tb_led_frame_swap_ctrl.sv
// tb/tb_led_frame_swap_ctrl.sv - scoreboard bench for led_frame_swap_ctrl
module tb_led_frame_swap_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    led_frame_swap_ctrl_if #(.ADDR_W(12), .PIXEL_W(8)) bus ();

    led_frame_swap_ctrl #(
        .ADDR_W      (12),
        .PIXEL_W     (8),
        .CLEAR_PIXEL (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         ready;
        bit         ack;
        bit         front;
        bit         we;
        bit         zero;
        logic [12:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: what the controller should be doing this cycle
    bit          m_pending;
    bit          m_clr;
    int          m_left;
    bit          m_front;
    bit          m_ack;
    bit          m_wr_pend;
    logic [12:0] m_wr_addr;
    logic [7:0]  m_wr_data;
    bit          m_after_rst;
    int          clears_started;
    bit          did_mid_reset;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    endtask

    task automatic model_reset();
        m_pending   = 0;
        m_clr       = 0;
        m_left      = 0;
        m_front     = 0;
        m_ack       = 0;
        m_wr_pend   = 0;
        m_wr_addr   = '0;
        m_wr_data   = '0;
        m_after_rst = 1;
    endtask

    // One clock cycle: record expected outputs, drive inputs, advance model across the edge
    task automatic cyc(input bit r, input bit d, input bit sr, input bit cr,
                       input bit wr, input logic [11:0] a, input logic [7:0] dt);
        exp_t e;
        bit   rdy;
        rdy     = !m_pending && (m_left == 0);
        e.ready = rdy;
        e.ack   = m_ack;
        e.front = m_front;
        e.we    = m_wr_pend || (m_left > 0);
        e.zero  = m_after_rst;
        if (m_left > 0) begin
            e.addr = {~m_front, 12'(4096 - m_left)};
            e.data = 8'h00;
        end else begin
            e.addr = m_wr_addr;
            e.data = m_wr_data;
        end
        exp_q.push_back(e);

        rst          = r;
        bus.done     = d;
        bus.swapReq  = sr;
        bus.clearReq = cr;
        bus.wrReq    = wr;
        bus.wrAddr   = a;
        bus.wrData   = dt;

        if (r) begin
            model_reset();
        end else begin
            m_after_rst = 0;
            m_ack       = 0;
            m_wr_pend   = 0;
            if (rdy) begin
                if (wr) begin
                    m_wr_pend = 1;
                    m_wr_addr = {~m_front, a};
                    m_wr_data = dt;
                end
                if (sr) begin
                    m_pending = 1;
                    m_clr     = cr;
                end
            end else if (m_pending) begin
                if (d) begin
                    m_front   = ~m_front;
                    m_ack     = 1;
                    m_pending = 0;
                    if (m_clr) begin
                        m_left = 4096;
                        clears_started++;
                    end
                end
            end else begin
                m_left--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 12'h000, 8'h00);
    endtask

    // Monitor: compare every cycle's DUT outputs against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("swapReady", {31'b0, bus.swapReady}, {31'b0, e.ready});
                chk("wrReady",   {31'b0, bus.wrReady},   {31'b0, e.ready});
                chk("frontSel",  {31'b0, bus.frontSel},  {31'b0, e.front});
                chk("swapAck",   {31'b0, bus.swapAck},   {31'b0, e.ack});
                chk("ramWe",     {31'b0, bus.ramWe},     {31'b0, e.we});
                if (e.zero) begin
                    chk("reset_ramAddr", {19'b0, bus.ramAddr}, 32'h0);
                    chk("reset_ramData", {24'b0, bus.ramData}, 32'h0);
                end else if (e.we) begin
                    chk("ramAddr", {19'b0, bus.ramAddr}, {19'b0, e.addr});
                    chk("ramData", {24'b0, bus.ramData}, {24'b0, e.data});
                end
            end
        end
    end

    // Stimulus: directed preamble, then randomized traffic
    initial begin
        bit          r, d, sr, cr, wr;
        logic [11:0] a;
        logic [7:0]  dt;
        int          pick;
        bus.done = 0; bus.swapReq = 0; bus.clearReq = 0;
        bus.wrReq = 0; bus.wrAddr = '0; bus.wrData = '0;
        clears_started = 0;
        did_mid_reset  = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        cyc(1, 0, 0, 0, 0, 12'h000, 8'h00);

        cyc(0, 0, 0, 0, 1, 12'd0,    8'h11);
        cyc(0, 0, 0, 0, 1, 12'd1,    8'h22);
        cyc(0, 0, 0, 0, 1, 12'd4095, 8'h33);
        idle(1);

        cyc(0, 0, 1, 0, 0, 12'h000, 8'h00);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 12'(i), 8'h5A);
        cyc(0, 1, 0, 0, 1, 12'h010, 8'h5B);
        idle(1);
        cyc(0, 0, 0, 0, 1, 12'h020, 8'h44);

        cyc(0, 1, 1, 1, 0, 12'h000, 8'h00);
        idle(3);
        cyc(0, 1, 0, 0, 0, 12'h000, 8'h00);
        for (int i = 0; i < 4100; i++) cyc(0, 0, 1, 0, 0, 12'h000, 8'h00);
        cyc(0, 1, 0, 0, 0, 12'h000, 8'h00);
        idle(2);

        for (int i = 0; i < 30000; i++) begin
            if (!did_mid_reset && clears_started >= 2 && m_left == 2096) begin
                r = 1;
                did_mid_reset = 1;
            end else begin
                r = ($urandom_range(0, 4999) == 0);
            end
            d    = ($urandom_range(0, 5) == 0);
            sr   = ($urandom_range(0, 7) == 0);
            cr   = ($urandom_range(0, 1) == 1);
            wr   = ($urandom_range(0, 9) < 7);
            pick = $urandom_range(0, 3);
            a    = (pick == 0) ? 12'd0 : (pick == 1) ? 12'd4095 : 12'($urandom);
            dt   = 8'($urandom);
            cyc(r, d, sr, cr, wr, a, dt);
        end
        idle(2);
        @(negedge clk);
        #1;
        if (!did_mid_reset) chk("mid_clear_reset_reached", 32'd0, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
